mem_access_unit: RTL

//  Sequential load/store engine downstream of memory decode. Accepts one access per transaction:
//  R/!W op, access_size, read_unsigned, address, store data.
//  Per transaction it does byte-lane steering, byte-enable generation, load sign/zero extension
//  and an optional two-beat split for misaligned accesses.

---
 rtl/mem_access_unit_if.sv | 48 ++++
 rtl/mem_access_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus signals of mem_access_unit.
// master: the load/store unit's view; slave: the execute stage plus memory bus view.
interface mem_access_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  // Request from the execute stage
  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;

  // Completion back to the execute stage
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_fault;

  // Word-aligned data-memory bus
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [NB-1:0]     bus_be;
  logic [XLEN-1:0]   bus_wdata;
  logic              bus_ack;
  logic [XLEN-1:0]   bus_rdata;

  modport master (
    input  req_valid, req_op, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_fault,
    output bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_req_ready, bus_ack, bus_rdata
  );

  modport slave (
    output req_valid, req_op, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_fault,
    input  bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_req_ready, bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequential load/store engine between execute and the data-memory bus.
// Does byte-lane steering, byte-enable generation and load sign/zero extension.
// Optional feature macro: MEM_MISALIGN_SPLIT_EN -- when defined, misaligned accesses are
// legal and those crossing a bus word are issued as two beats (lo then hi); when undefined,
// any misaligned access faults without touching the bus.
module mem_access_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_access_unit_if.master  io
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LO  = 3'd1,
    WAIT_LO = 3'd2,
    REQ_HI  = 3'd3,
    WAIT_HI = 3'd4,
    RESP    = 3'd5
  } state_t;

  // Byte enables over a two-word window: low half is the lo beat, high half the hi beat.
  function automatic logic [2*NB-1:0] lane_be(input logic [1:0] size, input logic [OFFW-1:0] off);
    logic [2*NB-1:0] m;
    int nbytes;
    m = '0;
    nbytes = int'(32'd1 << size);
    for (int i = 0; i < NB; i++) begin
      m[i] = (i < nbytes);
    end
    return m << off;
  endfunction

  // Store data shifted into its byte lanes over a two-word window.
  function automatic logic [2*XLEN-1:0] lane_wdata(input logic [XLEN-1:0] wdata, input logic [OFFW-1:0] off);
    return {{XLEN{1'b0}}, wdata} << {off, 3'b000};
  endfunction

  // Right-justify the loaded bytes and sign/zero extend; full-width loads pass unchanged.
  function automatic logic [XLEN-1:0] load_extend(input logic [2*XLEN-1:0] raw, input logic [OFFW-1:0] off,
                                                  input logic [1:0] size, input logic uns);
    logic [2*XLEN-1:0] sh;
    logic [XLEN-1:0]   s;
    logic [XLEN-1:0]   mask;
    logic [XLEN-1:0]   r;
    int nbits;
    sh    = raw >> {off, 3'b000};
    s     = sh[XLEN-1:0];
    mask  = '0;
    nbits = int'(32'd8 << size);
    if (nbits >= XLEN) begin
      r = s;
    end else begin
      mask = {XLEN{1'b1}} >> (XLEN - nbits);
      r    = s & mask;
      if (!uns && s[nbits-1]) begin
        r = r | ~mask;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  state_t            state;
  logic              ready_r;
  logic              resp_valid_r;
  logic [XLEN-1:0]   resp_rdata_r;
  logic              resp_fault_r;
  logic              bus_req_valid_r;
  logic              bus_we_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [NB-1:0]     bus_be_r;
  logic [XLEN-1:0]   bus_wdata_r;

  // Latched request and second-beat lanes
  logic              op_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic [OFFW-1:0]   off_r;
  logic              cross_r;
  logic [NB-1:0]     be_hi_r;
  logic [XLEN-1:0]   wdata_hi_r;
  logic [XLEN-1:0]   rdata_lo_r;

  logic              size_bad;
  logic              req_bad;
  logic [2*NB-1:0]   be_req;
  logic [2*XLEN-1:0] wd_req;

  assign be_req   = lane_be(io.req_size, io.req_addr[OFFW-1:0]);
  assign wd_req   = lane_wdata(io.req_wdata, io.req_addr[OFFW-1:0]);
  assign size_bad = int'(io.req_size) > OFFW;

`ifdef MEM_MISALIGN_SPLIT_EN
  assign req_bad = size_bad;
`else
  logic misaligned;
  assign misaligned = (io.req_addr[2:0] & ((3'd1 << io.req_size) - 3'd1)) != 3'd0;
  assign req_bad    = size_bad | misaligned;
`endif

  // Transaction FSM: request capture, bus beats, load assembly and one-cycle response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      ready_r         <= 1'b1;
      resp_valid_r    <= 1'b0;
      resp_rdata_r    <= '0;
      resp_fault_r    <= 1'b0;
      bus_req_valid_r <= 1'b0;
      bus_we_r        <= 1'b0;
      bus_addr_r      <= '0;
      bus_be_r        <= '0;
      bus_wdata_r     <= '0;
      op_r            <= 1'b0;
      size_r          <= 2'd0;
      uns_r           <= 1'b0;
      off_r           <= '0;
      cross_r         <= 1'b0;
      be_hi_r         <= '0;
      wdata_hi_r      <= '0;
      rdata_lo_r      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.req_valid && ready_r) begin
            ready_r    <= 1'b0;
            op_r       <= io.req_op;
            size_r     <= io.req_size;
            uns_r      <= io.req_unsigned;
            off_r      <= io.req_addr[OFFW-1:0];
            cross_r    <= |be_req[2*NB-1:NB];
            be_hi_r    <= be_req[2*NB-1:NB];
            wdata_hi_r <= wd_req[2*XLEN-1:XLEN];
            if (req_bad) begin
              resp_valid_r <= 1'b1;
              resp_fault_r <= 1'b1;
              resp_rdata_r <= '0;
              state        <= RESP;
            end else begin
              bus_req_valid_r <= 1'b1;
              bus_we_r        <= ~io.req_op;
              bus_addr_r      <= {io.req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
              bus_be_r        <= be_req[NB-1:0];
              bus_wdata_r     <= wd_req[XLEN-1:0];
              state           <= REQ_LO;
            end
          end else begin
            state <= IDLE;
          end
        end
        REQ_LO, REQ_HI: begin
          if (io.bus_req_ready) begin
            bus_req_valid_r <= 1'b0;
            state           <= (state == REQ_LO) ? WAIT_LO : WAIT_HI;
          end else begin
            state <= state;
          end
        end
        WAIT_LO: begin
          if (io.bus_ack) begin
            rdata_lo_r <= io.bus_rdata;
            if (cross_r) begin
              bus_req_valid_r <= 1'b1;
              bus_addr_r      <= bus_addr_r + ADDR_W'(NB);
              bus_be_r        <= be_hi_r;
              bus_wdata_r     <= wdata_hi_r;
              state           <= REQ_HI;
            end else begin
              resp_valid_r <= 1'b1;
              resp_fault_r <= 1'b0;
              resp_rdata_r <= op_r ? load_extend({{XLEN{1'b0}}, io.bus_rdata}, off_r, size_r, uns_r) : '0;
              state        <= RESP;
            end
          end else begin
            state <= WAIT_LO;
          end
        end
        WAIT_HI: begin
          if (io.bus_ack) begin
            resp_valid_r <= 1'b1;
            resp_fault_r <= 1'b0;
            resp_rdata_r <= op_r ? load_extend({io.bus_rdata, rdata_lo_r}, off_r, size_r, uns_r) : '0;
            state        <= RESP;
          end else begin
            state <= WAIT_HI;
          end
        end
        RESP: begin
          resp_valid_r <= 1'b0;
          resp_fault_r <= 1'b0;
          resp_rdata_r <= '0;
          ready_r      <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          bus_req_valid_r <= 1'b0;
          resp_valid_r    <= 1'b0;
          ready_r         <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end

  assign io.req_ready     = ready_r;
  assign io.resp_valid    = resp_valid_r;
  assign io.resp_rdata    = resp_rdata_r;
  assign io.resp_fault    = resp_fault_r;
  assign io.bus_req_valid = bus_req_valid_r;
  assign io.bus_we        = bus_we_r;
  assign io.bus_addr      = bus_addr_r;
  assign io.bus_be        = bus_be_r;
  assign io.bus_wdata     = bus_wdata_r;

endmodule
